// File: rtl/dmem_access_pkg.sv
// Shared encodings for the DMEM load/store front end: access sizes, FSM states
// and the default DMEM word-index width.
package dmem_access_pkg;

    localparam int unsigned DEF_ADDR_W = 5;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

    // Reserved size, or a halfword/word not on its natural boundary.
    function automatic logic access_bad(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/byte_lane_mux.sv
// Little-endian lane steering: extracts/extends load data from a DMEM word and
// merges sub-word store data into the captured word, leaving other lanes intact.
module byte_lane_mux
    import dmem_access_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        sign_ext_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_c_o,
    output logic [31:0] st_word_c_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Load path: pick the addressed lane, then replicate bit 7/15 or zero-fill.
    always_comb begin
        byte_sel    = 8'h00;
        half_sel    = 16'h0000;
        ld_data_c_o = rword_i;
        case (offset_i)
            2'd0:    byte_sel = rword_i[7:0];
            2'd1:    byte_sel = rword_i[15:8];
            2'd2:    byte_sel = rword_i[23:16];
            default: byte_sel = rword_i[31:24];
        endcase
        half_sel = offset_i[1] ? rword_i[31:16] : rword_i[15:0];
        case (size_i)
            SZ_BYTE: ld_data_c_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: ld_data_c_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
            default: ld_data_c_o = rword_i;
        endcase
    end

    // Store path: overwrite only the addressed lane of the read-back word.
    always_comb begin
        st_word_c_o = rword_i;
        case (size_i)
            SZ_BYTE: begin
                case (offset_i)
                    2'd0:    st_word_c_o[7:0]   = wdata_i[7:0];
                    2'd1:    st_word_c_o[15:8]  = wdata_i[7:0];
                    2'd2:    st_word_c_o[23:16] = wdata_i[7:0];
                    default: st_word_c_o[31:24] = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset_i[1]) begin
                    st_word_c_o[31:16] = wdata_i[15:0];
                end else begin
                    st_word_c_o[15:0] = wdata_i[15:0];
                end
            end
            SZ_WORD: st_word_c_o = wdata_i;
            default: st_word_c_o = rword_i;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store front end for a word-wide DMEM: one request at a time, alignment
// checking, read-modify-write for sub-word stores, extended load data.
module dmem_access_unit
    import dmem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              dmem_ena,
    output logic              dmem_wena,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ena_q, ena_d;
    logic              wena_q, wena_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [31:0]       dwdata_q, dwdata_d;

    logic [31:0]       ld_data;
    logic [31:0]       st_word;
    logic              unused_addr_hi;

    // Bytes above the DMEM window alias onto it; they are deliberately dropped.
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    byte_lane_mux u_lane (
        .size_i      (size_q),
        .offset_i    (off_q),
        .sign_ext_i  (sext_q),
        .rword_i     (dmem_rdata),
        .wdata_i     (wdata_q),
        .ld_data_c_o (ld_data),
        .st_word_c_o (st_word)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        sext_d   = sext_q;
        off_d    = off_q;
        wdata_d  = wdata_q;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    sext_d  = sign_ext;
                    off_d   = addr[1:0];
                    wdata_d = wdata;
                    daddr_d = addr[ADDR_W+1:2];
                    if (access_bad(size, addr[1:0])) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else if (!we || size != SZ_WORD) begin
                        state_d = RD;
                    end else begin
                        state_d  = WR;
                        dwdata_d = wdata;
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    state_d  = WR;
                    dwdata_d = st_word;
                end else begin
                    state_d = RESP;
                    rdata_d = ld_data;
                end
            end
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase

        // Strobes are registered off the next state so they line up with it.
        busy_d = (state_d != IDLE);
        done_d = (state_d == RESP);
        ena_d  = (state_d == RD) || (state_d == WR);
        wena_d = (state_d == WR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            sext_q   <= 1'b0;
            off_q    <= 2'b00;
            wdata_q  <= 32'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
            ena_q    <= 1'b0;
            wena_q   <= 1'b0;
            daddr_q  <= '0;
            dwdata_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            sext_q   <= sext_d;
            off_q    <= off_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            ena_q    <= ena_d;
            wena_q   <= wena_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign rdata      = rdata_q;
    assign dmem_ena   = ena_q;
    assign dmem_wena  = wena_q;
    assign dmem_addr  = daddr_q;
    assign dmem_wdata = dwdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a behavioural word-wide DMEM.
module tb_dmem_access_unit;

    localparam int unsigned AW = 5;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          we;
    logic [1:0]    size;
    logic          sign_ext;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   rdata;
    logic          dmem_ena;
    logic          dmem_wena;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic [31:0]   dmem_rdata;

    logic [31:0] mem [0:(1<<AW)-1];
    int          wr_count;
    int          n_checks;
    int          n_fail;

    dmem_access_unit #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .we         (we),
        .size       (size),
        .sign_ext   (sign_ext),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .dmem_ena   (dmem_ena),
        .dmem_wena  (dmem_wena),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dmem_rdata = mem[dmem_addr];

    initial wr_count = 0;
    always @(posedge clk) begin
        if (dmem_ena && dmem_wena) begin
            mem[dmem_addr] <= dmem_wdata;
            wr_count       <= wr_count + 1;
        end
    end

    // Issue one request and follow it to its done pulse (bounded), then let it return to IDLE.
    task automatic run_op(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int wrc, output int enc, output logic [AW-1:0] last_addr);
        lat = -1; rd = 32'h0; er = 1'b0; wrc = 0; enc = 0; last_addr = '0;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (dmem_ena) begin
                enc++;
                last_addr = dmem_addr;
            end
            if (dmem_wena) wrc++;
            if (done) begin
                lat = k + 1;
                rd  = rdata;
                er  = err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [73:0] obs;
        obs = {busy, done, err, rdata, dmem_ena, dmem_wena, dmem_addr, dmem_wdata};
        n_checks++;
        if (obs !== 74'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
    endtask

    task automatic test_word();
        int lat, wrc, enc; logic [31:0] rd; logic er; logic [AW-1:0] la;
        run_op(1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFF_0000, lat, rd, er, wrc, enc, la);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d expected 2", lat); end
        n_checks++;
        if (wrc !== 1 || enc !== 1) begin
            n_fail++; $display("FAIL sw_wr_cycles: got wr=%0d ena=%0d expected 1/1", wrc, enc);
        end
        n_checks++;
        if (mem[0] !== 32'hFFFF_0000) begin n_fail++; $display("FAIL sw_mem: got %h expected ffff0000", mem[0]); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL sw_busy_idle: got %b expected 0", busy); end
        run_op(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, rd, er, wrc, enc, la);
        n_checks++;
        if (lat !== 2 || er !== 1'b0) begin
            n_fail++; $display("FAIL lw_timing: got lat=%0d err=%b expected 2/0", lat, er);
        end
        n_checks++;
        if (rd !== 32'hFFFF_0000) begin n_fail++; $display("FAIL lw_data: got %h expected ffff0000", rd); end
    endtask

    task automatic test_byte();
        int lat, wrc, enc; logic [31:0] rd; logic er; logic [AW-1:0] la;
        run_op(1'b1, 2'b10, 1'b0, 32'h4, 32'h1122_3344, lat, rd, er, wrc, enc, la);
        run_op(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, lat, rd, er, wrc, enc, la);
        n_checks++;
        if (rd !== 32'h0000_0011) begin n_fail++; $display("FAIL lb_07: got %h expected 00000011", rd); end
        run_op(1'b1, 2'b00, 1'b0, 32'h5, 32'hDEAD_BE80, lat, rd, er, wrc, enc, la);
        n_checks++;
        if (mem[1] !== 32'h1122_8044) begin n_fail++; $display("FAIL sb_merge: got %h expected 11228044", mem[1]); end
        n_checks++;
        if (lat !== 3 || wrc !== 1) begin
            n_fail++; $display("FAIL sb_timing: got lat=%0d wr=%0d expected 3/1", lat, wrc);
        end
        run_op(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, lat, rd, er, wrc, enc, la);
        n_checks++;
        if (rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_sext: got %h expected ffffff80", rd); end
        run_op(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, lat, rd, er, wrc, enc, la);
        n_checks++;
        if (rd !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_zext: got %h expected 00000080", rd); end
    endtask

    task automatic test_half();
        int lat, wrc, enc; logic [31:0] rd; logic er; logic [AW-1:0] la;
        run_op(1'b1, 2'b10, 1'b0, 32'h8, 32'h0, lat, rd, er, wrc, enc, la);
        run_op(1'b1, 2'b01, 1'b0, 32'hA, 32'h1234_BEEF, lat, rd, er, wrc, enc, la);
        n_checks++;
        if (mem[2] !== 32'hBEEF_0000) begin n_fail++; $display("FAIL sh_merge: got %h expected beef0000", mem[2]); end
        n_checks++;
        if (lat !== 3 || enc !== 2 || wrc !== 1) begin
            n_fail++; $display("FAIL sh_seq: got lat=%0d ena=%0d wr=%0d expected 3/2/1", lat, enc, wrc);
        end
        run_op(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, lat, rd, er, wrc, enc, la);
        n_checks++;
        if (rd !== 32'hFFFF_BEEF) begin n_fail++; $display("FAIL lh: got %h expected ffffbeef", rd); end
        run_op(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, lat, rd, er, wrc, enc, la);
        n_checks++;
        if (rd !== 32'h0000_BEEF) begin n_fail++; $display("FAIL lhu: got %h expected 0000beef", rd); end
    endtask

    task automatic test_errors();
        int lat, wrc, enc; logic [31:0] rd; logic er; logic [AW-1:0] la;
        logic [31:0] prev;
        logic        ew [0:2];
        logic [1:0]  es [0:2];
        logic [31:0] ea [0:2];
        ew[0] = 1'b0; es[0] = 2'b10; ea[0] = 32'h2;
        ew[1] = 1'b1; es[1] = 2'b01; ea[1] = 32'h3;
        ew[2] = 1'b0; es[2] = 2'b11; ea[2] = 32'h0;
        prev = 32'h0000_BEEF;
        for (int i = 0; i < 3; i++) begin
            run_op(ew[i], es[i], 1'b1, ea[i], 32'h5555_5555, lat, rd, er, wrc, enc, la);
            n_checks++;
            if (lat !== 1 || er !== 1'b1 || enc !== 0) begin
                n_fail++;
                $display("FAIL err_case%0d: got lat=%0d err=%b ena=%0d expected 1/1/0", i, lat, er, enc);
            end
            n_checks++;
            if (rd !== prev) begin n_fail++; $display("FAIL err_rdata%0d: got %h expected %h", i, rd, prev); end
        end
        n_checks++;
        if (mem[0] !== 32'hFFFF_0000) begin n_fail++; $display("FAIL err_nowrite: got %h expected ffff0000", mem[0]); end
    endtask

    task automatic test_wrap_ignore();
        int lat, wrc, enc, nd; logic [31:0] rd; logic er; logic [AW-1:0] la;
        run_op(1'b1, 2'b10, 1'b0, 32'h84, 32'hCAFE_BABE, lat, rd, er, wrc, enc, la);
        n_checks++;
        if (la !== 5'd1 || er !== 1'b0) begin
            n_fail++; $display("FAIL wrap_addr: got dmem_addr=%0d err=%b expected 1/0", la, er);
        end
        run_op(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, rd, er, wrc, enc, la);
        n_checks++;
        if (rd !== 32'hCAFE_BABE) begin n_fail++; $display("FAIL wrap_load: got %h expected cafebabe", rd); end
        // Hold req through the busy window; it must not start a second access.
        nd = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h4;
        @(posedge clk); #1;
        addr = 32'h0;
        @(posedge clk); #1;
        if (done) nd++;
        @(posedge clk); #1;
        req = 1'b0;
        if (done) nd++;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        n_checks++;
        if (nd !== 1) begin n_fail++; $display("FAIL ignore_busy_req: got %0d done pulses expected 1", nd); end
        n_checks++;
        if (rdata !== 32'hCAFE_BABE) begin n_fail++; $display("FAIL ignore_rdata: got %h expected cafebabe", rdata); end
    endtask

    task automatic test_reset_abort();
        int lat, wrc, enc, wc0; logic [31:0] rd; logic er; logic [AW-1:0] la;
        logic [73:0] obs;
        run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hA5A5_A5A5, lat, rd, er, wrc, enc, la);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h10; wdata = 32'h0;
        @(posedge clk); #1;
        req = 1'b0;
        n_checks++;
        if (dmem_ena !== 1'b1 || dmem_wena !== 1'b0) begin
            n_fail++; $display("FAIL abort_in_rd: got ena=%b wena=%b expected 1/0", dmem_ena, dmem_wena);
        end
        wc0 = wr_count;
        rst_n = 1'b0;
        #1;
        obs = {busy, done, err, rdata, dmem_ena, dmem_wena, dmem_addr, dmem_wdata};
        n_checks++;
        if (obs !== 74'd0) begin n_fail++; $display("FAIL abort_outputs: got %h expected 0", obs); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (mem[4] !== 32'hA5A5_A5A5 || wr_count !== wc0) begin
            n_fail++; $display("FAIL abort_nowrite: got %h writes=%0d expected a5a5a5a5 writes=%0d", mem[4], wr_count, wc0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, lat, rd, er, wrc, enc, la);
        n_checks++;
        if (lat !== 2 || mem[4] !== 32'h1234_5678) begin
            n_fail++; $display("FAIL post_reset_sw: got lat=%0d mem=%h expected 2/12345678", lat, mem[4]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        req      = 1'b0;
        we       = 1'b0;
        size     = 2'b00;
        sign_ext = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_wrap_ignore();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
